loader_write_fifo: RTL and testbench
====================================

LOADER_WRITE_FIFO -- requirements
Module: loader_write_fifo

Interface
REQ-001 Parameter DEPTH, default 8: FIFO entries; power of two, minimum 2.
REQ-002 Parameter AW, default 22: SDRAM byte-address width.
REQ-003 clk  in  1  system clock (21 MHz NES domain); only clock; all logic on rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset; sampled on rising clk.
REQ-005 flush  in  1  synchronous clear of queue; driven high while no download is active.
REQ-006 wr_en  in  1  one-cycle write strobe from GameLoader (mem_write).
REQ-007 wr_addr  in  AW  GameLoader byte address.
REQ-008 wr_data  in  8  GameLoader byte data.
REQ-009 slot  in  1  one-cycle SDRAM write-slot strobe (nes_ce==3); period 4 clk nominal, any period >=1 legal.
REQ-010 mem_we  out  1  SDRAM write enable, registered, constant between slot edges.
REQ-011 mem_addr  out  AW  SDRAM write address, registered.
REQ-012 mem_data  out  8  SDRAM write data, registered.
REQ-013 count  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 full  out  1  count==DEPTH.
REQ-015 busy  out  1  count!=0 or mem_we==1; loader_done gating uses this.
REQ-016 overflow  out  1  sticky flag: a write was dropped.

Function
REQ-017 Storage: circular buffer, DEPTH entries of {addr, data}; read/write pointers log2(DEPTH) bits, wrap modulo DEPTH.
REQ-018 Push: wr_en=1 and (count<DEPTH or pop this cycle) -> entry written at write pointer, pointer +1.
REQ-019 Push with count==DEPTH and no pop this cycle -> entry dropped, overflow<=1, pointers unchanged.
REQ-020 Pop: occurs only on a clk edge with slot=1 and count!=0; head loaded into mem_addr/mem_data, mem_we<=1, read pointer +1.
REQ-021 Slot with count==0 -> mem_we<=0; mem_addr/mem_data hold previous values.
REQ-022 mem_we, mem_addr, mem_data change only on slot edges, flush, or reset; each issued write is held exactly one slot period.
REQ-023 No bypass: a push and a slot on the same edge with count==0 -> entry enqueued, written at the next slot (latency >=1 slot).
REQ-024 Simultaneous push and pop: count unchanged; when full, push accepted (no overflow).
REQ-025 count updates same edge as push/pop: +1 push only, -1 pop only, unchanged both/neither.
REQ-026 Order: SDRAM writes issued strictly in push order; no entry issued twice.
REQ-027 flush=1: pointers and count<=0, mem_we<=0, overflow<=0; wr_en and slot on that edge ignored; mem_addr/mem_data hold.
REQ-028 Priority per edge: reset_n=0 > flush > push/pop.
REQ-029 full and busy combinational from registered state; no combinational path from wr_en or slot to any output.

Reset
REQ-030 reset_n=0 on a clk edge: count=0, pointers=0, mem_we=0, mem_addr=0, mem_data=0, overflow=0; full=0, busy=0 thereafter.
REQ-031 reset_n low mid-operation: queued and in-flight writes discarded; first push after release lands at entry 0.
REQ-032 Storage array contents need no reset.

Verification
REQ-033 Reset, then push {0x000010,0xA5} with slot every 4 clk -> at next slot edge mem_we=1, mem_addr=0x000010, mem_data=0xA5 held 4 clk; next slot mem_we=0; busy falls with mem_we.
REQ-034 Push 8 entries (addr 0..7, data 0x10..0x17) with no slot -> count=8, full=1; 9th push -> overflow=1, count=8; then slots drain addr 0..7 in order, data 0x10..0x17, no 9th write.
REQ-035 With count=8, push and slot same edge -> count stays 8, overflow stays 0, new entry appears last in drain order.
REQ-036 count=0, push and slot same edge -> mem_we=0 that slot; write issued at following slot.
REQ-037 count=5 and mem_we=1, assert flush one cycle -> count=0, mem_we=0, overflow=0; later slots issue no writes until new push.
REQ-038 Wrap-around: 20 pushes, one every 4 clk, slot every 4 clk offset 2 -> 20 writes in order, count never >2, overflow=0.

Source files
------------

// File: rtl/loader_write_fifo.sv
// loader_write_fifo
// Decouples GameLoader byte writes from the SDRAM write slot. Bytes are queued in
// a small circular buffer and issued one per slot strobe in push order. Each issued
// write is held on mem_we/mem_addr/mem_data for one full slot period.

module loader_write_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 22
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_flush,
    input  logic                     i_wr_en,
    input  logic [AW-1:0]            i_wr_addr,
    input  logic [7:0]               i_wr_data,
    input  logic                     i_slot,
    output logic                     o_mem_we,
    output logic [AW-1:0]            o_mem_addr,
    output logic [7:0]               o_mem_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_busy,
    output logic                     o_overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Storage: no reset needed, pointers/count define validity
    logic [AW-1:0] r_store_addr [DEPTH];
    logic [7:0]    r_store_data [DEPTH];

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [7:0]    r_mem_data;
    logic          r_overflow;

    logic          w_empty;
    logic          w_is_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [CW-1:0] w_count_nxt;
    logic [PW-1:0] w_wptr_nxt;
    logic [PW-1:0] w_rptr_nxt;

    // Push/pop decisions; a pop frees the slot a same-edge push needs when full
    always_comb begin
        w_empty   = (r_count == '0);
        w_is_full = (r_count == FULL_COUNT);
        w_pop     = i_slot && !w_empty;
        w_push    = i_wr_en && (!w_is_full || w_pop);
        w_drop    = i_wr_en && !w_push;
    end

    // Next pointer and occupancy values; pointer width makes wrap modulo DEPTH
    always_comb begin
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        w_count_nxt = r_count;
        if (w_push) begin
            w_wptr_nxt = r_wptr + 1'b1;
        end
        if (w_pop) begin
            w_rptr_nxt = r_rptr + 1'b1;
        end
        unique case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Entry write; suppressed under reset/flush so the array never sees ignored strobes
    always_ff @(posedge i_clk) begin
        if (i_reset_n && !i_flush && w_push) begin
            r_store_addr[r_wptr] <= i_wr_addr;
            r_store_data[r_wptr] <= i_wr_data;
        end
    end

    // Queue bookkeeping with priority reset > flush > push/pop
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // SDRAM write port: only moves on slot edges; address/data hold across idle slots
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else if (i_flush) begin
            r_mem_we <= 1'b0;
        end else if (i_slot) begin
            r_mem_we <= w_pop;
            if (w_pop) begin
                r_mem_addr <= r_store_addr[r_rptr];
                r_mem_data <= r_store_data[r_rptr];
            end
        end
    end

    // Outputs derive from registered state only
    always_comb begin
        o_mem_we   = r_mem_we;
        o_mem_addr = r_mem_addr;
        o_mem_data = r_mem_data;
        o_count    = r_count;
        o_full     = (r_count == FULL_COUNT);
        o_busy     = (r_count != '0) || r_mem_we;
        o_overflow = r_overflow;
    end

endmodule

// File: tb/tb_loader_write_fifo.sv
// Self-checking bench for loader_write_fifo: directed scenarios plus randomized
// traffic, all compared against a queue-based reference model.

module tb_loader_write_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 22;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned VW    = 1 + AW + 8 + CW + 3;

    logic          clk;
    logic          reset_n;
    logic          flush;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          slot;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic [CW-1:0] count;
    logic          full;
    logic          busy;
    logic          overflow;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a plain queue of pending {addr,data} plus the output register
    logic [AW+7:0] mq[$];
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_data;
    logic          m_ovf;

    // Writes observed on the DUT port, one per slot edge that issued a write
    logic [AW+7:0] dut_wr[$];

    loader_write_fifo #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_flush   (flush),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_slot    (slot),
        .o_mem_we  (mem_we),
        .o_mem_addr(mem_addr),
        .o_mem_data(mem_data),
        .o_count   (count),
        .o_full    (full),
        .o_busy    (busy),
        .o_overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [VW-1:0] dut_vec();
        return {mem_we, mem_addr, mem_data, count, full, busy, overflow};
    endfunction

    function automatic logic [VW-1:0] mdl_vec();
        logic [CW-1:0] c;
        c = CW'(mq.size());
        return {m_we, m_addr, m_data, c, (mq.size() == DEPTH), ((mq.size() != 0) || m_we), m_ovf};
    endfunction

    // Drive one cycle of inputs, advance the model on the edge, sample 1ns later
    task automatic tick(input logic rst_n, input logic fl, input logic we,
                        input logic [AW-1:0] a, input logic [7:0] d, input logic sl);
        logic [AW+7:0] e;
        int            had;
        reset_n = rst_n;
        flush   = fl;
        wr_en   = we;
        wr_addr = a;
        wr_data = d;
        slot    = sl;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_we = 1'b0; m_addr = '0; m_data = '0; m_ovf = 1'b0;
        end else if (fl) begin
            mq.delete();
            m_we = 1'b0; m_ovf = 1'b0;
        end else begin
            had = mq.size();
            if (sl) begin
                if (had > 0) begin
                    e = mq.pop_front();
                    m_we = 1'b1; m_addr = e[AW+7:8]; m_data = e[7:0];
                end else begin
                    m_we = 1'b0;
                end
            end
            if (we) begin
                if (had < DEPTH || (sl && had > 0)) mq.push_back({a, d});
                else m_ovf = 1'b1;
            end
        end
        #1;
        if (rst_n && !fl && sl && mem_we) dut_wr.push_back({mem_addr, mem_data});
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b0, 1'b1, 22'h3AAAAA, 8'h55, 1'b1);
        tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        n_cmp++;
        if (dut_vec() !== '0) begin
            n_err++; $display("FAIL reset_state: got %h want 0", dut_vec());
        end
        // Mid-operation reset discards queued and in-flight writes
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1, AW'(i + 100), 8'(i), (i == 2));
        tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        n_cmp++;
        if (dut_vec() !== '0) begin
            n_err++; $display("FAIL reset_mid: got %h want 0", dut_vec());
        end
        dut_wr.delete();
        tick(1'b1, 1'b0, 1'b1, 22'h000123, 8'h77, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, 1'b0, '0, '0, (i % 2 == 0));
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL reset_after: got %h want %h", dut_vec(), mdl_vec());
            end
        end
        n_cmp++;
        if (dut_wr.size() != 1 || dut_wr[0] !== {22'h000123, 8'h77}) begin
            n_err++;
            $display("FAIL reset_after_writes: got %0d writes want 1 of 000123/77", dut_wr.size());
        end
    endtask

    task automatic test_single();
        tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int c = 0; c < 12; c++) begin
            tick(1'b1, 1'b0, (c == 0), 22'h000010, 8'hA5, (c % 4 == 3));
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL single_model c=%0d: got %h want %h", c, dut_vec(), mdl_vec());
            end
            if (c >= 3 && c <= 6) begin
                n_cmp++;
                if ({mem_we, mem_addr, mem_data, busy} !== {1'b1, 22'h000010, 8'hA5, 1'b1}) begin
                    n_err++;
                    $display("FAIL single_hold c=%0d: got we=%b a=%h d=%h busy=%b want 1/000010/a5/1",
                             c, mem_we, mem_addr, mem_data, busy);
                end
            end
            if (c == 7) begin
                n_cmp++;
                if ({mem_we, busy} !== 2'b00) begin
                    n_err++; $display("FAIL single_release: got we=%b busy=%b want 0/0", mem_we, busy);
                end
            end
        end
    endtask

    task automatic test_overflow();
        tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        dut_wr.delete();
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b1, AW'(i), 8'(8'h10 + i), 1'b0);
        n_cmp++;
        if ({count, full, overflow} !== {CW'(8), 1'b1, 1'b0}) begin
            n_err++; $display("FAIL fill8: got count=%0d full=%b ovf=%b want 8/1/0", count, full, overflow);
        end
        tick(1'b1, 1'b0, 1'b1, 22'h000008, 8'h99, 1'b0);
        n_cmp++;
        if ({count, overflow} !== {CW'(8), 1'b1}) begin
            n_err++; $display("FAIL push9: got count=%0d ovf=%b want 8/1", count, overflow);
        end
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b0, 1'b0, '0, '0, (i % 2 == 0));
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL drain_model i=%0d: got %h want %h", i, dut_vec(), mdl_vec());
            end
        end
        n_cmp++;
        if (dut_wr.size() != 8) begin
            n_err++; $display("FAIL drain_count: got %0d want 8", dut_wr.size());
        end
        for (int i = 0; i < 8 && i < dut_wr.size(); i++) begin
            n_cmp++;
            if (dut_wr[i] !== {AW'(i), 8'(8'h10 + i)}) begin
                n_err++; $display("FAIL drain_order i=%0d: got %h want %h", i, dut_wr[i],
                                  {AW'(i), 8'(8'h10 + i)});
            end
        end
    endtask

    task automatic test_full_pushpop();
        logic [AW+7:0] exp[$];
        tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        dut_wr.delete();
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, 1'b1, AW'(i), 8'(8'h10 + i), 1'b0);
            exp.push_back({AW'(i), 8'(8'h10 + i)});
        end
        tick(1'b1, 1'b0, 1'b1, 22'h0003FF, 8'hEE, 1'b1);
        exp.push_back({22'h0003FF, 8'hEE});
        n_cmp++;
        if ({count, overflow} !== {CW'(8), 1'b0}) begin
            n_err++; $display("FAIL full_pushpop: got count=%0d ovf=%b want 8/0", count, overflow);
        end
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b0, '0, '0, (i % 2 == 1));
        n_cmp++;
        if (dut_wr.size() != 9) begin
            n_err++; $display("FAIL full_pushpop_count: got %0d want 9", dut_wr.size());
        end
        for (int i = 0; i < 9 && i < dut_wr.size(); i++) begin
            n_cmp++;
            if (dut_wr[i] !== exp[i]) begin
                n_err++; $display("FAIL full_pushpop_order i=%0d: got %h want %h", i, dut_wr[i], exp[i]);
            end
        end
    endtask

    task automatic test_no_bypass();
        tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 22'h00ABCD, 8'h3C, 1'b1);
        n_cmp++;
        if ({mem_we, count} !== {1'b0, CW'(1)}) begin
            n_err++; $display("FAIL no_bypass: got we=%b count=%0d want 0/1", mem_we, count);
        end
        tick(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
        n_cmp++;
        if ({mem_we, mem_addr, mem_data} !== {1'b1, 22'h00ABCD, 8'h3C}) begin
            n_err++; $display("FAIL no_bypass_next: got we=%b a=%h d=%h want 1/00abcd/3c",
                              mem_we, mem_addr, mem_data);
        end
    endtask

    task automatic test_flush();
        logic [AW-1:0] held_a;
        logic [7:0]    held_d;
        tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 9; i++) tick(1'b1, 1'b0, 1'b1, AW'(i + 32), 8'(i + 1), 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
        n_cmp++;
        if ({count, mem_we, overflow} !== {CW'(5), 1'b1, 1'b1}) begin
            n_err++; $display("FAIL pre_flush: got count=%0d we=%b ovf=%b want 5/1/1",
                              count, mem_we, overflow);
        end
        held_a = mem_addr;
        held_d = mem_data;
        tick(1'b1, 1'b1, 1'b1, 22'h155555, 8'hCC, 1'b1);
        n_cmp++;
        if ({count, mem_we, overflow, mem_addr, mem_data} !==
            {CW'(0), 1'b0, 1'b0, AW'(34), 8'h03}) begin
            n_err++; $display("FAIL flush: got count=%0d we=%b ovf=%b a=%h d=%h want 0/0/0/000022/03",
                              count, mem_we, overflow, mem_addr, mem_data);
        end
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
            n_cmp++;
            if ({mem_we, busy, mem_addr, mem_data} !== {1'b0, 1'b0, held_a, held_d}) begin
                n_err++; $display("FAIL post_flush i=%0d: got we=%b busy=%b want 0/0", i, mem_we, busy);
            end
        end
    endtask

    task automatic test_wrap();
        logic [AW+7:0] exp[$];
        logic [AW-1:0] a;
        logic [7:0]    d;
        int            maxc;
        tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        dut_wr.delete();
        maxc = 0;
        for (int c = 0; c < 88; c++) begin
            a = AW'($urandom);
            d = 8'($urandom);
            if (c % 4 == 0 && c < 80) exp.push_back({a, d});
            tick(1'b1, 1'b0, (c % 4 == 0 && c < 80), a, d, (c % 4 == 2));
            if (int'(count) > maxc) maxc = int'(count);
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL wrap_model c=%0d: got %h want %h", c, dut_vec(), mdl_vec());
            end
        end
        n_cmp++;
        if (maxc > 2 || overflow !== 1'b0 || dut_wr.size() != 20) begin
            n_err++; $display("FAIL wrap_summary: got max=%0d ovf=%b writes=%0d want <=2/0/20",
                              maxc, overflow, dut_wr.size());
        end
        for (int i = 0; i < 20 && i < dut_wr.size(); i++) begin
            n_cmp++;
            if (dut_wr[i] !== exp[i]) begin
                n_err++; $display("FAIL wrap_order i=%0d: got %h want %h", i, dut_wr[i], exp[i]);
            end
        end
    endtask

    task automatic test_random();
        int sl_mod;
        for (int c = 0; c < 3000; c++) begin
            sl_mod = ((c / 200) % 3 == 0) ? 8 : (((c / 200) % 3 == 1) ? 2 : 1);
            tick(($urandom_range(0, 299) != 0), ($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 1) == 1), AW'($urandom), 8'($urandom),
                 ($urandom_range(0, sl_mod - 1) == 0));
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL random c=%0d: got %h want %h", c, dut_vec(), mdl_vec());
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        flush   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        slot    = 1'b0;
        test_reset();
        test_single();
        test_overflow();
        test_full_pushpop();
        test_no_bypass();
        test_flush();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
